// File: rtl/platform_pkg.sv
// Platform-wide constants shared by bus slaves: Wishbone address width and
// machine-timer register offsets and default tick rate.
// Pure declarations: no latency, no flow control.
package platform_pkg;

  // Wishbone word address width used across the platform interconnect
  localparam int WB_AW = 30;

  // Machine timer clock cycles per mtime increment (platform top default)
  localparam int MTIMER_CLKS_PER_TICK = 1;

  // Machine timer word offsets, decoded from wb_adr[1:0]
  localparam logic [1:0] MTIMER_MTIME_LO_OFF    = 2'd0;
  localparam logic [1:0] MTIMER_MTIME_HI_OFF    = 2'd1;
  localparam logic [1:0] MTIMER_MTIMECMP_LO_OFF = 2'd2;
  localparam logic [1:0] MTIMER_MTIMECMP_HI_OFF = 2'd3;

  // Replace the byte lanes of cur_val selected by sel with those of wr_val
  function automatic logic [31:0] byte_merge(input logic [31:0] cur_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = cur_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = wr_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp + level irq) as a pipelined Wishbone B4 slave.
// Latency: every accepted request is acked exactly one cycle later; irq follows register changes by one cycle.
// Backpressure: none, stall is tied low and a request is accepted every cycle cyc&stb is high.
// Optional build macro MTIMER_SHADOW_READ_EN: a word-0 read latches mtime[63:32] so a
// following word-1 read returns a tear-free high half.
module wb_mtimer
  import platform_pkg::*;
#(
  parameter int CLKS_PER_TICK = platform_pkg::MTIMER_CLKS_PER_TICK,
  parameter int WB_AW         = platform_pkg::WB_AW
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [WB_AW-1:0] wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_stall_o,
  output logic             timer_irq_o
);

  // Prescaler width covers a terminal count of CLKS_PER_TICK-1 (up to 2^16-1)
  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          ack_q;
  logic [31:0]   dat_q, dat_d;
  logic          irq_q;

  logic          tick;
  logic          accept;
  logic          rd_req;
  logic [1:0]    word;
  logic          wr_mtime_lo, wr_mtime_hi;
  logic          wr_cmp_lo, wr_cmp_hi;
  logic [31:0]   rd_mux;
  logic [31:0]   mtime_hi_rd;

  // Only the low two address bits select a register; the rest are ignored
  logic adr_unused;
  assign adr_unused = ^wb_adr_i[WB_AW-1:2];

  assign word       = wb_adr_i[1:0];
  assign accept     = wb_cyc_i & wb_stb_i;
  assign rd_req     = accept & ~wb_we_i;
  assign wb_stall_o = 1'b0;

`ifdef MTIMER_SHADOW_READ_EN
  logic [31:0] shadow_q, shadow_d;

  // Capture the high half whenever the low half is read, so the pair is coherent
  always_comb begin
    shadow_d = shadow_q;
    if (rd_req && (word == MTIMER_MTIME_LO_OFF)) begin
      shadow_d = mtime_q[63:32];
    end
  end

  // Shadow register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      shadow_q <= 32'd0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  // Decode writes, compute next register values and the read response
  always_comb begin
    tick        = (presc_q == PRESC_LAST);
    presc_d     = tick ? '0 : presc_q + 1'b1;

    wr_mtime_lo = accept & wb_we_i & (word == MTIMER_MTIME_LO_OFF);
    wr_mtime_hi = accept & wb_we_i & (word == MTIMER_MTIME_HI_OFF);
    wr_cmp_lo   = accept & wb_we_i & (word == MTIMER_MTIMECMP_LO_OFF);
    wr_cmp_hi   = accept & wb_we_i & (word == MTIMER_MTIMECMP_HI_OFF);

    // A software write to either mtime half wins over the tick; unwritten
    // bytes keep the pre-increment value
    mtime_d = mtime_q;
    if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) begin
        mtime_d[31:0] = byte_merge(mtime_q[31:0], wb_dat_i, wb_sel_i);
      end
      if (wr_mtime_hi) begin
        mtime_d[63:32] = byte_merge(mtime_q[63:32], wb_dat_i, wb_sel_i);
      end
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) begin
      mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
    end
    if (wr_cmp_hi) begin
      mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
    end

    // Reads see the value present in the accept cycle
    rd_mux = 32'd0;
    case (word)
      MTIMER_MTIME_LO_OFF:    rd_mux = mtime_q[31:0];
      MTIMER_MTIME_HI_OFF:    rd_mux = mtime_hi_rd;
      MTIMER_MTIMECMP_LO_OFF: rd_mux = mtimecmp_q[31:0];
      MTIMER_MTIMECMP_HI_OFF: rd_mux = mtimecmp_q[63:32];
      default:                rd_mux = 32'd0;
    endcase

    // Write acks and idle cycles return zero data
    dat_d = rd_req ? rd_mux : 32'd0;
  end

  // State registers, bus response and interrupt level
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      presc_q    <= '0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ack_q      <= accept;
      dat_q      <= dat_d;
      // Compare the registered (already updated) values, so any change to
      // mtime or mtimecmp reaches the irq one cycle later
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed self-checking bench for wb_mtimer with CLKS_PER_TICK=1.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each issue() call occupies exactly one bus cycle, so consecutive calls are back-to-back.
module tb_wb_mtimer;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_adr = '0;
  logic [3:0]    wb_sel = 4'h0;
  logic [31:0]   wb_wdat = 32'd0;
  logic [31:0]   wb_rdat;
  logic          wb_ack;
  logic          wb_stall;
  logic          irq;

  int errors = 0;
  int checks = 0;

  wb_mtimer #(.CLKS_PER_TICK(1), .WB_AW(AW)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_we_i     (wb_we),
    .wb_adr_i    (wb_adr),
    .wb_sel_i    (wb_sel),
    .wb_dat_i    (wb_wdat),
    .wb_dat_o    (wb_rdat),
    .wb_ack_o    (wb_ack),
    .wb_stall_o  (wb_stall),
    .timer_irq_o (irq)
  );

  always #5 clk = ~clk;

  // One request for one cycle; returns the ack/data seen after that edge
  task automatic issue(input logic we, input logic [1:0] a, input logic [3:0] sel,
                       input logic [31:0] d, output logic ack, output logic [31:0] rd);
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_we   = we;
    wb_adr  = AW'(a);
    wb_sel  = sel;
    wb_wdat = d;
    @(negedge clk);
    ack     = wb_ack;
    rd      = wb_rdat;
    wb_cyc  = 1'b0;
    wb_stb  = 1'b0;
    wb_we   = 1'b0;
  endtask

  task automatic do_reset();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    rstn   = 1'b0;
    repeat (2) @(negedge clk);
    rstn   = 1'b1;
  endtask

  task automatic test_reset();
    logic ack;
    logic [31:0] rd;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wb_ack !== 1'b0 || wb_rdat !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, want 0 0 0", wb_ack, wb_rdat, irq);
    end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    issue(1'b0, 2'd0, 4'hF, 32'd0, ack, rd);
    checks++;
    if (ack !== 1'b1 || rd !== 32'd10) begin
      errors++;
      $display("FAIL idle_mtime_lo: ack=%b dat=%h, want 1 0000000a", ack, rd);
    end
    issue(1'b0, 2'd1, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL idle_mtime_hi: got %h want 00000000", rd);
    end
    issue(1'b0, 2'd3, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_mtimecmp_hi: got %h want ffffffff", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL idle_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_byte_lanes();
    logic ack;
    logic [31:0] rd;
    do_reset();
    issue(1'b1, 2'd2, 4'b0010, 32'h0000_AB00, ack, rd);
    checks++;
    if (ack !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL write_ack: ack=%b dat=%h, want 1 00000000", ack, rd);
    end
    issue(1'b0, 2'd2, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'hFFFF_ABFF) begin
      errors++;
      $display("FAIL byte_lane_cmp_lo: got %h want ffffabff", rd);
    end
  endtask

  task automatic test_carry();
    logic ack;
    logic [31:0] rd;
    do_reset();
    issue(1'b1, 2'd0, 4'hF, 32'hFFFF_FFFE, ack, rd);
    issue(1'b1, 2'd1, 4'hF, 32'h0000_0000, ack, rd);
    // mtime = 0_FFFFFFFE now; three ticks reach 1_00000001
    repeat (3) @(negedge clk);
    issue(1'b0, 2'd0, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL carry_lo: got %h want 00000001", rd);
    end
    issue(1'b0, 2'd1, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL carry_hi: got %h want 00000001", rd);
    end
    // Wrap from all-ones to zero
    issue(1'b1, 2'd0, 4'hF, 32'hFFFF_FFFF, ack, rd);
    issue(1'b1, 2'd1, 4'hF, 32'hFFFF_FFFF, ack, rd);
    issue(1'b0, 2'd0, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_before: got %h want ffffffff", rd);
    end
    issue(1'b0, 2'd0, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL wrap_lo: got %h want 00000000", rd);
    end
    issue(1'b0, 2'd1, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL wrap_hi: got %h want 00000000", rd);
    end
  endtask

  task automatic test_compare();
    logic ack;
    logic [31:0] rd;
    do_reset();
    issue(1'b1, 2'd3, 4'hF, 32'd0, ack, rd);
    issue(1'b1, 2'd2, 4'hF, 32'd100, ack, rd);
    issue(1'b1, 2'd1, 4'hF, 32'd0, ack, rd);
    issue(1'b1, 2'd0, 4'hF, 32'd90, ack, rd);
    // mtime = 90 here; 9 more ticks give 99
    repeat (9) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_at_99: got %b want 0", irq);
    end
    @(negedge clk);
    // mtime just reached 100; irq follows one cycle later
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_at_reach: got %b want 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    issue(1'b1, 2'd3, 4'hF, 32'd1, ack, rd);
    checks++;
    if (ack !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_at_ack: ack=%b irq=%b, want 1 1", ack, irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
  endtask

  task automatic test_priority();
    logic ack;
    logic [31:0] rd;
    do_reset();
    issue(1'b1, 2'd0, 4'hF, 32'd5, ack, rd);
    issue(1'b0, 2'd0, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'd5) begin
      errors++;
      $display("FAIL write_over_tick: got %h want 00000005", rd);
    end
    // mtime = 6 now; replace byte 1 only, no increment this cycle
    issue(1'b1, 2'd0, 4'b0010, 32'h0000_1200, ack, rd);
    issue(1'b0, 2'd0, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'h0000_1206) begin
      errors++;
      $display("FAIL mtime_byte_lane: got %h want 00001206", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [31:0] rd;
    logic [31:0] exp_tab [4];
    logic [1:0]  adr_tab [4];
    exp_tab = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
    adr_tab = '{2'd2, 2'd3, 2'd2, 2'd3};
    do_reset();
    issue(1'b1, 2'd2, 4'hF, 32'h1234_5678, ack, rd);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, adr_tab[i], 4'hF, 32'd0, ack, rd);
      checks++;
      if (ack !== 1'b1 || rd !== exp_tab[i] || wb_stall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_read%0d: ack=%b dat=%h stall=%b, want 1 %h 0",
                 i, ack, rd, wb_stall, exp_tab[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single_ack: ack=%b want 0", wb_ack);
    end
  endtask

  task automatic test_cyc_low();
    wb_cyc = 1'b0;
    wb_stb = 1'b1;
    wb_adr = AW'(2'd2);
    @(negedge clk);
    wb_stb = 1'b0;
    checks++;
    if (wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL cyc_low_no_ack: ack=%b want 0", wb_ack);
    end
  endtask

  task automatic test_reset_drop();
    logic ack;
    logic [31:0] rd;
    issue(1'b1, 2'd2, 4'hF, 32'd0, ack, rd);
    // Request accepted in the same cycle reset is asserted
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b0;
    wb_adr = AW'(2'd2);
    rstn   = 1'b0;
    @(negedge clk);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    checks++;
    if (wb_ack !== 1'b0 || wb_rdat !== 32'd0) begin
      errors++;
      $display("FAIL reset_drops_ack: ack=%b dat=%h, want 0 00000000", wb_ack, wb_rdat);
    end
    rstn = 1'b1;
    issue(1'b0, 2'd0, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_mtime: got %h want 00000000", rd);
    end
    issue(1'b0, 2'd2, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_mtimecmp_lo: got %h want ffffffff", rd);
    end
  endtask

  task automatic test_shadow();
    logic ack;
    logic [31:0] rd;
    logic [31:0] exp_hi;
`ifdef MTIMER_SHADOW_READ_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    do_reset();
    issue(1'b1, 2'd0, 4'hF, 32'hFFFF_FFFF, ack, rd);
    issue(1'b1, 2'd1, 4'hF, 32'h0000_0000, ack, rd);
    issue(1'b0, 2'd0, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL pair_lo: got %h want ffffffff", rd);
    end
    issue(1'b0, 2'd1, 4'hF, 32'd0, ack, rd);
    checks++;
    if (rd !== exp_hi) begin
      errors++;
      $display("FAIL pair_hi: got %h want %h", rd, exp_hi);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_carry();
    test_compare();
    test_priority();
    test_back_to_back();
    test_cyc_low();
    test_reset_drop();
    test_shadow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
